// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, syncs, blanking, line/frame strobes and frame counter.
// Optional macro VGA_TIMING_REGISTERED_SYNC_EN delays hsync/vsync/display_on/vblank by one extra clk.
module vga_timing_gen #(
   parameter int   H_DISPLAY  = 640,
   parameter int   H_FRONT    = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BACK     = 48,
   parameter int   V_DISPLAY  = 480,
   parameter int   V_BOTTOM   = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_TOP      = 33,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0,
   parameter int   FRAME_W    = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               freeze,
   output logic [9:0]         hpos,
   output logic [9:0]         vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               vblank,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

   // Counters are 10 bits wide; larger rasters are rejected at elaboration.
   if (H_TOTAL > 1024) begin : g_h_total_too_big
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_v_total_too_big
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_DISP_L = 10'(H_DISPLAY);
   localparam logic [9:0] V_DISP_L = 10'(V_DISPLAY);
   localparam logic [9:0] H_SS     = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SE     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SS     = 10'(V_DISPLAY + V_BOTTOM);
   localparam logic [9:0] V_SE     = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

   logic [9:0]         r_hpos;
   logic [9:0]         r_vpos;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_display_on;
   logic               r_vblank;
   logic               r_line_start;
   logic               r_frame_start;
   logic [FRAME_W-1:0] r_frame;

   logic       w_hwrap;
   logic       w_vwrap;
   logic [9:0] w_hpos_nxt;
   logic [9:0] w_vpos_nxt;
   logic       w_hsync_nxt;
   logic       w_vsync_nxt;
   logic       w_display_on_nxt;
   logic       w_vblank_nxt;
   logic       w_line_start_nxt;
   logic       w_frame_start_nxt;

   // Decode every flag from the next counter values so the registered
   // flags land in the same cycle as the counters they describe.
   always_comb begin
      w_hwrap    = (r_hpos == H_LAST);
      w_vwrap    = (r_vpos == V_LAST);
      w_hpos_nxt = r_hpos + 10'd1;
      w_vpos_nxt = r_vpos;
      if (w_hwrap) begin
         w_hpos_nxt = '0;
         w_vpos_nxt = w_vwrap ? '0 : r_vpos + 10'd1;
      end
      w_hsync_nxt       = ((w_hpos_nxt >= H_SS) && (w_hpos_nxt <= H_SE)) ? H_SYNC_POL : ~H_SYNC_POL;
      w_vsync_nxt       = ((w_vpos_nxt >= V_SS) && (w_vpos_nxt <= V_SE)) ? V_SYNC_POL : ~V_SYNC_POL;
      w_display_on_nxt  = (w_hpos_nxt < H_DISP_L) && (w_vpos_nxt < V_DISP_L);
      w_vblank_nxt      = (w_vpos_nxt >= V_DISP_L);
      w_line_start_nxt  = w_hwrap;
      w_frame_start_nxt = w_hwrap & w_vwrap;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hpos        <= '0;
         r_vpos        <= '0;
         r_hsync       <= ~H_SYNC_POL;
         r_vsync       <= ~V_SYNC_POL;
         r_display_on  <= 1'b1;
         r_vblank      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame       <= '0;
      end else begin
         r_hpos        <= w_hpos_nxt;
         r_vpos        <= w_vpos_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_display_on  <= w_display_on_nxt;
         r_vblank      <= w_vblank_nxt;
         r_line_start  <= w_line_start_nxt;
         r_frame_start <= w_frame_start_nxt;
         if (w_frame_start_nxt && !freeze) begin
            r_frame <= r_frame + FRAME_W'(1);
         end
      end
   end

`ifdef VGA_TIMING_REGISTERED_SYNC_EN
   logic r_hsync_d;
   logic r_vsync_d;
   logic r_display_on_d;
   logic r_vblank_d;

   // Extra stage lines the syncs up with a registered pixel path downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hsync_d      <= ~H_SYNC_POL;
         r_vsync_d      <= ~V_SYNC_POL;
         r_display_on_d <= 1'b1;
         r_vblank_d     <= 1'b0;
      end else begin
         r_hsync_d      <= r_hsync;
         r_vsync_d      <= r_vsync;
         r_display_on_d <= r_display_on;
         r_vblank_d     <= r_vblank;
      end
   end

   assign hsync      = r_hsync_d;
   assign vsync      = r_vsync_d;
   assign display_on = r_display_on_d;
   assign vblank     = r_vblank_d;
`else
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign display_on = r_display_on;
   assign vblank     = r_vblank;
`endif

   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame       = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 15x12 raster with a 2-bit frame counter.
// Honours VGA_TIMING_REGISTERED_SYNC_EN when the design is built with it.
module tb_vga_timing_gen;

   localparam int HD = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 2;
   localparam int VD = 6;
   localparam int VB = 2;
   localparam int VS = 2;
   localparam int VT = 2;
   localparam int FW = 2;
   localparam int H_TOT = HD + HF + HS + HB;   // 15
   localparam int V_TOT = VD + VB + VS + VT;   // 12
   localparam int FRAME_CYC = H_TOT * V_TOT;   // 180

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          freeze = 1'b0;
   logic [9:0]    hpos;
   logic [9:0]    vpos;
   logic          hsync;
   logic          vsync;
   logic          display_on;
   logic          vblank;
   logic          line_start;
   logic          frame_start;
   logic [FW-1:0] frame;

   vga_timing_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FRAME_W(FW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze),
      .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
      .display_on(display_on), .vblank(vblank),
      .line_start(line_start), .frame_start(frame_start), .frame(frame)
   );

   // Clock block
   always #5 clk = ~clk;

   // Reference model state
   int   n_vec = 0;
   int   n_err = 0;
   int   m_h = 0;
   int   m_v = 0;
   int   m_frame = 0;
   logic m_ls = 1'b0;
   logic m_fs = 1'b0;
   logic [3:0] m_flags = 4'b1110;   // {hsync, vsync, display_on, vblank}

   // Observed-pulse tallies, cleared by the sequence before each window
   int cnt_hs_lo = 0;
   int cnt_vs_lo = 0;
   int cnt_vb_hi = 0;
   int cnt_de_lo = 0;
   int cnt_fs = 0;

   // Flag values a correctly timed raster shows at position (h, v); syncs active low.
   function automatic logic [3:0] decode(input int h, input int v);
      logic hs, vs, de, vb;
      hs = (h >= HD + HF && h < HD + HF + HS) ? 1'b0 : 1'b1;
      vs = (v >= VD + VB && v < VD + VB + VS) ? 1'b0 : 1'b1;
      de = (h < HD) && (v < VD);
      vb = (v >= VD);
      return {hs, vs, de, vb};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at model (%0d,%0d): observed=%0h expected=%0h", tag, m_h, m_v, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".hpos"}, 32'(hpos), 32'(m_h));
      chk({tag, ".vpos"}, 32'(vpos), 32'(m_v));
      chk({tag, ".hsync"}, 32'(hsync), 32'(m_flags[3]));
      chk({tag, ".vsync"}, 32'(vsync), 32'(m_flags[2]));
      chk({tag, ".display_on"}, 32'(display_on), 32'(m_flags[1]));
      chk({tag, ".vblank"}, 32'(vblank), 32'(m_flags[0]));
      chk({tag, ".line_start"}, 32'(line_start), 32'(m_ls));
      chk({tag, ".frame_start"}, 32'(frame_start), 32'(m_fs));
      chk({tag, ".frame"}, 32'(frame), 32'(m_frame));
   endtask

   // Driver: one clock edge, advance the model, return on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_h = 0;
         m_v = 0;
         m_ls = 1'b0;
         m_fs = 1'b0;
         m_frame = 0;
         m_flags = 4'b1110;
      end else begin
`ifdef VGA_TIMING_REGISTERED_SYNC_EN
         m_flags = decode(m_h, m_v);
`endif
         m_h = m_h + 1;
         if (m_h == H_TOT) begin
            m_h = 0;
            m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
         end
         m_ls = (m_h == 0);
         m_fs = (m_h == 0) && (m_v == 0);
         if (m_fs && !freeze) m_frame = (m_frame + 1) % (1 << FW);
`ifndef VGA_TIMING_REGISTERED_SYNC_EN
         m_flags = decode(m_h, m_v);
`endif
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         check_all(tag);
         if (hsync == 1'b0) cnt_hs_lo++;
         if (vsync == 1'b0) cnt_vs_lo++;
         if (vblank == 1'b1) cnt_vb_hi++;
         if (display_on == 1'b0) cnt_de_lo++;
         if (frame_start == 1'b1) cnt_fs++;
      end
   endtask

   task automatic clear_counts();
      cnt_hs_lo = 0;
      cnt_vs_lo = 0;
      cnt_vb_hi = 0;
      cnt_de_lo = 0;
      cnt_fs = 0;
   endtask

   initial begin
      @(negedge clk);
      // Reset held for three edges
      rst_n = 1'b0;
      repeat (3) tick();
      check_all("reset");
      chk("reset_hsync_inactive", 32'(hsync), 32'd1);
      chk("reset_display_on", 32'(display_on), 32'd1);

      // Release: still at (0,0) until the next edge
      rst_n = 1'b1;
      check_all("released");
      tick();
      check_all("first_count");
      chk("first_count_hpos", 32'(hpos), 32'd1);

      // Rest of line 0 up to the wrap into line 1
      clear_counts();
      run(H_TOT - 1, "line0");
      chk("line0_hsync_width", 32'(cnt_hs_lo), 32'd3);
      chk("line0_de_low", 32'(cnt_de_lo), 32'd7);
      chk("line1_line_start", 32'(line_start), 32'd1);
      chk("line1_vpos", 32'(vpos), 32'd1);
      chk("line1_no_frame_start", 32'(frame_start), 32'd0);

      // Remainder of frame 0 up to the wrap to (0,0)
      clear_counts();
      run(FRAME_CYC - H_TOT, "frame0");
      chk("frame0_vsync_cycles", 32'(cnt_vs_lo), 32'd30);
      chk("frame0_vblank_cycles", 32'(cnt_vb_hi), 32'd90);
      chk("frame0_fs_count", 32'(cnt_fs), 32'd1);
      chk("frame0_wrap_fs", 32'(frame_start), 32'd1);
      chk("frame0_wrap_frame", 32'(frame), 32'd1);
      chk("frame0_wrap_hpos", 32'(hpos), 32'd0);

      // Freeze across two wraps: strobes continue, counter holds
      freeze = 1'b1;
      clear_counts();
      run(2 * FRAME_CYC, "frozen");
      chk("frozen_fs_count", 32'(cnt_fs), 32'd2);
      chk("frozen_frame", 32'(frame), 32'd1);
      freeze = 1'b0;
      run(FRAME_CYC, "unfrozen");
      chk("unfrozen_frame", 32'(frame), 32'd2);

      // 2-bit counter: 2 -> 3 -> 0
      run(FRAME_CYC, "to_three");
      chk("frame_three", 32'(frame), 32'd3);
      run(FRAME_CYC, "to_wrap");
      chk("frame_wrapped", 32'(frame), 32'd0);
      run(FRAME_CYC, "to_one");
      chk("frame_one_again", 32'(frame), 32'd1);

      // Reset mid-frame at (5,4)
      run(4 * H_TOT + 5, "to_mid");
      chk("mid_hpos", 32'(hpos), 32'd5);
      chk("mid_vpos", 32'(vpos), 32'd4);
      rst_n = 1'b0;
      tick();
      check_all("mid_reset");
      chk("mid_reset_frame", 32'(frame), 32'd0);
      chk("mid_reset_fs", 32'(frame_start), 32'd0);
      chk("mid_reset_ls", 32'(line_start), 32'd0);
      rst_n = 1'b1;
      tick();
      check_all("after_mid_reset");
      chk("after_mid_reset_hpos", 32'(hpos), 32'd1);
      run(H_TOT, "post_reset_line");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
